// File: rtl/branch_target_predictor_pkg.sv
// Shared encodings and helpers for the branch target predictor.
// Holds the predictor mode codes, the counter reset constant and the tag/index width helpers.
package branch_target_predictor_pkg;

  localparam int MODE_STATIC  = 0;
  localparam int MODE_BIMODAL = 1;
  localparam int MODE_GSHARE  = 2;

  localparam int DEF_WORD_SIZE  = 16;
  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_TAG_BITS   = DEF_WORD_SIZE - DEF_INDEX_BITS;

  // Widest counter the weakly-taken helper can describe
  localparam int MAX_CTR_BITS = 16;

  typedef enum logic [1:0] {
    UPD_NONE     = 2'd0,
    UPD_ALLOCATE = 2'd1,
    UPD_HIT_COND = 2'd2,
    UPD_HIT_JUMP = 2'd3
  } upd_kind_e;

  function automatic logic [MAX_CTR_BITS-1:0] weak_taken(input int ctr_bits);
    logic [MAX_CTR_BITS-1:0] v;
    v = '0;
    v[ctr_bits-1] = 1'b1;
    return v;
  endfunction

  function automatic int tag_bits(input int word_size, input int index_bits);
    return word_size - index_bits;
  endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// Saturating up/down counter next-state logic shared by all BTB entries.
// Only the entry being updated is routed through it, so one instance serves the whole table.
module sat_counter
  import branch_target_predictor_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                inc,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;

  // step towards taken or not-taken, holding at either end
  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) begin
        ctr_next = ctr + CTR_BITS'(1);
      end else begin
        ctr_next = ctr;
      end
    end else begin
      if (ctr != CTR_ZERO) begin
        ctr_next = ctr - CTR_BITS'(1);
      end else begin
        ctr_next = ctr;
      end
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// IF-stage branch target predictor: direct-mapped BTB with per-entry saturating counters,
// selectable static / bimodal / gshare direction policy, and lookup/mispredict statistics.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 1,
  parameter int GHR_BITS   = 4,
  parameter int STAT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pred_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_next_pc,
  input  logic                 lookup_en,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_is_cond,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_mispredict,
  output logic [STAT_BITS-1:0] stat_lookups,
  output logic [STAT_BITS-1:0] stat_mispred
);

  localparam int ENTRIES  = 2 ** INDEX_BITS;
  localparam int TAG_BITS = tag_bits(WORD_SIZE, INDEX_BITS);

  localparam logic [CTR_BITS-1:0]  CTR_ALL  = '1;
  localparam logic [CTR_BITS-1:0]  CTR_WEAK = CTR_BITS'(weak_taken(CTR_BITS));
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic                 valid_r   [ENTRIES];
  logic [TAG_BITS-1:0]  tag_r     [ENTRIES];
  logic [WORD_SIZE-1:0] target_r  [ENTRIES];
  logic                 is_jump_r [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_r     [ENTRIES];
  logic [GHR_BITS-1:0]  ghr_r;
  logic [STAT_BITS-1:0] stat_lookups_r;
  logic [STAT_BITS-1:0] stat_mispred_r;

  logic [INDEX_BITS-1:0] ghr_idx_s;
  logic [INDEX_BITS-1:0] pred_idx_s;
  logic [TAG_BITS-1:0]   pred_tag_s;
  logic [INDEX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0]   upd_tag_s;
  logic                  upd_hit_s;
  logic                  upd_dir_s;
  logic [CTR_BITS-1:0]   sat_next_s;
  upd_kind_e             upd_kind_s;
  logic [WORD_SIZE-1:0]  wr_target_s;
  logic                  wr_jump_s;
  logic [CTR_BITS-1:0]   wr_ctr_s;

  // history folded into the index only in gshare mode; both ports use the pre-update GHR
  always_comb begin
    ghr_idx_s = '0;
    if (MODE == MODE_GSHARE) begin
      ghr_idx_s = INDEX_BITS'(ghr_r);
    end else begin
      ghr_idx_s = '0;
    end
  end

  assign pred_idx_s = pred_pc[INDEX_BITS-1:0] ^ ghr_idx_s;
  assign pred_tag_s = pred_pc[WORD_SIZE-1:INDEX_BITS];
  assign upd_idx_s  = upd_pc[INDEX_BITS-1:0] ^ ghr_idx_s;
  assign upd_tag_s  = upd_pc[WORD_SIZE-1:INDEX_BITS];
  assign upd_hit_s  = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
  assign upd_dir_s  = upd_taken | ~upd_is_cond;

  // zero-latency lookup straight from table state, no bypass of a same-cycle write
  always_comb begin
    pred_hit     = valid_r[pred_idx_s] && (tag_r[pred_idx_s] == pred_tag_s);
    pred_taken   = 1'b0;
    pred_next_pc = pred_pc + WORD_SIZE'(1);
    if (MODE == MODE_STATIC) begin
      pred_taken = 1'b0;
    end else begin
      pred_taken = pred_hit && (is_jump_r[pred_idx_s] || ctr_r[pred_idx_s][CTR_BITS-1]);
    end
    if (pred_taken) begin
      pred_next_pc = target_r[pred_idx_s];
    end else begin
      pred_next_pc = pred_pc + WORD_SIZE'(1);
    end
  end

  sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr      (ctr_r[upd_idx_s]),
    .inc      (upd_dir_s),
    .ctr_next (sat_next_s)
  );

  // classify the resolved instruction against the entry it maps to
  always_comb begin
    upd_kind_s = UPD_NONE;
    if (!upd_valid) begin
      upd_kind_s = UPD_NONE;
    end else if (upd_hit_s) begin
      if (upd_is_cond) begin
        upd_kind_s = UPD_HIT_COND;
      end else begin
        upd_kind_s = UPD_HIT_JUMP;
      end
    end else if (upd_dir_s) begin
      upd_kind_s = UPD_ALLOCATE;
    end else begin
      upd_kind_s = UPD_NONE;
    end
  end

  // new contents of the indexed entry; a hit also refreshes the stored instruction kind
  always_comb begin
    wr_target_s = target_r[upd_idx_s];
    wr_jump_s   = is_jump_r[upd_idx_s];
    wr_ctr_s    = ctr_r[upd_idx_s];
    case (upd_kind_s)
      UPD_ALLOCATE: begin
        wr_target_s = upd_target;
        wr_jump_s   = ~upd_is_cond;
        if (upd_is_cond) begin
          wr_ctr_s = CTR_WEAK;
        end else begin
          wr_ctr_s = CTR_ALL;
        end
      end
      UPD_HIT_COND: begin
        wr_jump_s = 1'b0;
        wr_ctr_s  = sat_next_s;
        if (upd_taken) begin
          wr_target_s = upd_target;
        end else begin
          wr_target_s = target_r[upd_idx_s];
        end
      end
      UPD_HIT_JUMP: begin
        wr_target_s = upd_target;
        wr_jump_s   = 1'b1;
        wr_ctr_s    = CTR_ALL;
      end
      default: begin
        wr_target_s = target_r[upd_idx_s];
        wr_jump_s   = is_jump_r[upd_idx_s];
        wr_ctr_s    = ctr_r[upd_idx_s];
      end
    endcase
  end

  // BTB table write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]   <= 1'b0;
        tag_r[i]     <= '0;
        target_r[i]  <= '0;
        is_jump_r[i] <= 1'b0;
        ctr_r[i]     <= '0;
      end
    end else if (upd_kind_s != UPD_NONE) begin
      valid_r[upd_idx_s]   <= 1'b1;
      tag_r[upd_idx_s]     <= upd_tag_s;
      target_r[upd_idx_s]  <= wr_target_s;
      is_jump_r[upd_idx_s] <= wr_jump_s;
      ctr_r[upd_idx_s]     <= wr_ctr_s;
    end
  end

  // global history shifts on conditional outcomes only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_r <= '0;
    end else if ((MODE == MODE_GSHARE) && upd_valid && upd_is_cond) begin
      ghr_r <= GHR_BITS'({ghr_r, upd_taken});
    end
  end

  // saturating statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups_r <= '0;
      stat_mispred_r <= '0;
    end else begin
      if (lookup_en && (stat_lookups_r != STAT_MAX)) begin
        stat_lookups_r <= stat_lookups_r + STAT_BITS'(1);
      end
      if (upd_valid && upd_mispredict && (stat_mispred_r != STAT_MAX)) begin
        stat_mispred_r <= stat_mispred_r + STAT_BITS'(1);
      end
    end
  end

  assign stat_lookups = stat_lookups_r;
  assign stat_mispred = stat_mispred_r;

endmodule
